// File: rtl/sample_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sample_delay_line
// Description : Programmable 0..255 sample delay for an ADC sample stream,
//               held in a 256 x 14-bit circular buffer. Define
//               SAMPLE_DELAY_ECHO_EN to add the optional echo mix
//               (current + delayed, halved). With the macro undefined,
//               mix_en is ignored and the plain delayed word is output.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_delay_line (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic        sample_strobe,
  input  logic [13:0] sample_in,
  input  logic [7:0]  delay,
  input  logic        mix_en,
  output logic [13:0] sample_out,
  output logic        out_valid,
  output logic        filled
);

  localparam int unsigned DATA_W  = 14;
  localparam int unsigned DEPTH   = 256;
  localparam logic [7:0]  FILL_MAX = 8'hFF;

  // History buffer: not reset, because the fill counter keeps stale words
  // from ever reaching the output.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [7:0]        wr_ptr_q,     wr_ptr_d;
  logic [7:0]        fill_count_q, fill_count_d;
  logic [DATA_W-1:0] sample_out_q, sample_out_d;
  logic              out_valid_q,  out_valid_d;
  logic              filled_q,     filled_d;

  logic [7:0]        rd_addr;
  logic              have_history;
  logic [DATA_W-1:0] delayed_word;
  logic [DATA_W-1:0] result_word;

  // Read address and delayed-word selection, evaluated before this cycle's write.
  always_comb begin
    rd_addr      = wr_ptr_q - delay;
    have_history = (fill_count_q >= delay);
    if (delay == 8'd0) begin
      delayed_word = sample_in;
    end else if (have_history) begin
      delayed_word = mem_q[rd_addr];
    end else begin
      delayed_word = '0;
    end
  end

`ifdef SAMPLE_DELAY_ECHO_EN
  logic signed [DATA_W:0] mix_sum;

  // Echo mix: 15-bit signed sum so the halved result can never overflow.
  always_comb begin
    mix_sum = $signed({sample_in[DATA_W-1], sample_in})
            + $signed({delayed_word[DATA_W-1], delayed_word});
    if (mix_en) begin
      result_word = mix_sum[DATA_W:1];
    end else begin
      result_word = delayed_word;
    end
  end
`else
  // mix_en has no function in this build; tie it off for lint.
  logic unused_mix_en;
  assign unused_mix_en = mix_en;

  // No mixing: the delayed word goes straight out.
  always_comb begin
    result_word = delayed_word;
  end
`endif

  // Next-state logic: all state advances only on a strobe; out_valid self-clears.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    fill_count_d = fill_count_q;
    sample_out_d = sample_out_q;
    filled_d     = filled_q;
    out_valid_d  = 1'b0;
    if (sample_strobe) begin
      wr_ptr_d     = wr_ptr_q + 8'd1;
      fill_count_d = (fill_count_q == FILL_MAX) ? FILL_MAX : fill_count_q + 8'd1;
      sample_out_d = result_word;
      filled_d     = have_history;
      out_valid_d  = 1'b1;
    end
  end

  // State registers with synchronous reset; reset wins over a coincident strobe.
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      fill_count_q <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      filled_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      fill_count_q <= fill_count_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      filled_q     <= filled_d;
    end
  end

  // Buffer write; suppressed under reset so a coincident strobe leaves no trace.
  always_ff @(posedge CLK_50M) begin
    if (sample_strobe && !reset) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign sample_out = sample_out_q;
  assign filled     = filled_q;
  // A reset raised in the cycle right after a strobe hides that strobe's pulse
  // immediately rather than one cycle late.
  assign out_valid  = out_valid_q && !reset;

endmodule
`default_nettype wire

// File: tb/tb_sample_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_delay_line
// Description : Directed self-checking bench for sample_delay_line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_delay_line;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_strobe = 1'b0;
  logic [13:0] sample_in = '0;
  logic [7:0]  delay = '0;
  logic        mix_en = 1'b0;
  logic [13:0] sample_out;
  logic        out_valid;
  logic        filled;

  int n_checks = 0;
  int n_errors = 0;

  sample_delay_line dut (
    .CLK_50M       (clk),
    .reset         (reset),
    .sample_strobe (sample_strobe),
    .sample_in     (sample_in),
    .delay         (delay),
    .mix_en        (mix_en),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .filled        (filled)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated strobe, then check the registered result one clock later.
  task automatic strobe_chk(input logic [13:0] v, input logic [13:0] exp_o,
                            input logic exp_f, input string tag);
    @(negedge clk);
    sample_strobe = 1'b1;
    sample_in     = v;
    @(negedge clk);
    sample_strobe = 1'b0;
    check_val({tag, ".valid"},  32'(out_valid),  32'd1);
    check_val({tag, ".out"},    32'(sample_out), 32'(exp_o));
    check_val({tag, ".filled"}, 32'(filled),     32'(exp_f));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [13:0] exp_tab [5];
    logic [13:0] v;

    // Reset state
    do_reset();
    check_val("rst.out",    32'(sample_out), 32'd0);
    check_val("rst.valid",  32'(out_valid),  32'd0);
    check_val("rst.filled", 32'(filled),     32'd0);

    // delay = 0 passes the live sample straight through
    delay = 8'd0;
    strobe_chk(14'h1234, 14'h1234, 1'b1, "d0");
    @(negedge clk);
    check_val("d0.hold.valid", 32'(out_valid),  32'd0);
    check_val("d0.hold.out",   32'(sample_out), 32'h1234);

    // delay = 3, samples 1..5 -> 0,0,0,1,2; filled rises on the 4th
    do_reset();
    delay = 8'd3;
    exp_tab = '{14'd0, 14'd0, 14'd0, 14'd1, 14'd2};
    for (int i = 0; i < 5; i++) begin
      strobe_chk(14'(i + 1), exp_tab[i], (i >= 3), $sformatf("d3.%0d", i));
    end

    // Raise delay beyond the history (5 samples): midscale, not filled
    delay = 8'd10;
    strobe_chk(14'd6, 14'd0, 1'b0, "dchg.up");
    // Drop delay to 2: buffer holds 1..6, so the word two back is 5
    delay = 8'd2;
    strobe_chk(14'd7, 14'd5, 1'b1, "dchg.down");

    // Back-to-back strobes, delay = 1: 10..14 -> 0,10,11,12,13
    do_reset();
    delay = 8'd1;
    exp_tab = '{14'd0, 14'd10, 14'd11, 14'd12, 14'd13};
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_val($sformatf("b2b.valid%0d", i - 1), 32'(out_valid),  32'd1);
        check_val($sformatf("b2b.out%0d", i - 1),   32'(sample_out), 32'(exp_tab[i - 1]));
      end
      if (i < 5) begin
        sample_strobe = 1'b1;
        sample_in     = 14'(10 + i);
      end else begin
        sample_strobe = 1'b0;
      end
    end
    @(negedge clk);
    check_val("b2b.valid_end", 32'(out_valid), 32'd0);

    // Reset coincident with a strobe mid-stream
    strobe_chk(14'd20, 14'd14, 1'b1, "pre_rst");
    @(negedge clk);
    reset         = 1'b1;
    sample_strobe = 1'b1;
    sample_in     = 14'h0099;
    @(negedge clk);
    reset         = 1'b0;
    sample_strobe = 1'b0;
    check_val("rst_strb.valid",  32'(out_valid),  32'd0);
    check_val("rst_strb.out",    32'(sample_out), 32'd0);
    check_val("rst_strb.filled", 32'(filled),     32'd0);

    // Reset in the cycle right after a strobe hides its out_valid
    delay = 8'd0;
    @(negedge clk);
    sample_strobe = 1'b1;
    sample_in     = 14'h0321;
    @(negedge clk);
    sample_strobe = 1'b0;
    reset         = 1'b1;
    #1;
    check_val("rst_after.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_after.out", 32'(sample_out), 32'd0);

    // delay = 255 ramp across the pointer wrap
    do_reset();
    delay = 8'd255;
    for (int n = 1; n <= 600; n++) begin
      v = (n >= 256) ? 14'(n - 255) : 14'd0;
      strobe_chk(14'(n), v, (n >= 256), $sformatf("ramp.%0d", n));
    end

`ifdef SAMPLE_DELAY_ECHO_EN
    // Echo mix at the positive and negative extremes
    do_reset();
    delay  = 8'd1;
    mix_en = 1'b1;
    strobe_chk(14'h1FFF, 14'h0FFF, 1'b0, "mix.p0");
    strobe_chk(14'h1FFF, 14'h1FFF, 1'b1, "mix.p1");
    strobe_chk(14'h2000, 14'h3FFF, 1'b1, "mix.n0");
    strobe_chk(14'h2000, 14'h2000, 1'b1, "mix.n1");
    mix_en = 1'b0;
    strobe_chk(14'h0055, 14'h2000, 1'b1, "mix.off");
`else
    // mix_en has no effect in the plain build
    do_reset();
    delay  = 8'd1;
    mix_en = 1'b1;
    strobe_chk(14'h1FFF, 14'h0000, 1'b0, "nomix.0");
    strobe_chk(14'h0ABC, 14'h1FFF, 1'b1, "nomix.1");
    mix_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
